// File: rtl/fetch_queue.sv
// 8080 instruction prefetch queue: two-byte program reads, head-opcode length decode, 24-bit instruction out.
// Define FETCH_HLT_STOP_EN to make an accepted HLT stop prefetch until redirect or reset.
module fetch_queue #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          QDEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_ren,
    output logic [15:0] mem_raddr,
    input  logic [15:0] mem_rdata,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [23:0] instr,
    output logic [15:0] instr_pc,
    output logic [1:0]  instr_len
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 2;
    localparam logic [CW-1:0] ISSUE_LIMIT = CW'(QDEPTH - 2);
    localparam logic [CW-1:0] COUNT_MAX   = CW'(QDEPTH);

    logic [7:0]    queue_q [QDEPTH];
    logic [PW-1:0] rdPtr_q, rdPtr_d, wrPtr_q, wrPtr_d;
    logic [PW-1:0] rdPtr1, rdPtr2, wrPtr1;
    logic [CW-1:0] count_q, count_d, committed;
    logic          inflight_q, inflight_d;
    logic [15:0]   fetchPc_q, fetchPc_d, instrPc_q, instrPc_d;
    logic          halted_q, hltTake;
    logic [7:0]    head, byte1, byte2;
    logic [1:0]    headLen;
    logic          push, pop, issue, flush;

    assign rdPtr1 = rdPtr_q + PW'(1);
    assign rdPtr2 = rdPtr_q + PW'(2);
    assign wrPtr1 = wrPtr_q + PW'(1);
    assign head   = queue_q[rdPtr_q];
    assign byte1  = queue_q[rdPtr1];
    assign byte2  = queue_q[rdPtr2];

    always_comb begin
        casez (head)
            8'b00??0001, 8'h22, 8'h2A, 8'h32, 8'h3A, 8'hC3, 8'hCD,
            8'b11???010, 8'b11???100:               headLen = 2'd3;
            8'b00???110, 8'b11???110, 8'hDB, 8'hD3: headLen = 2'd2;
            default:                                headLen = 2'd1;
        endcase
    end

    // A returning read still occupies space, so it counts against the issue limit.
    assign committed   = count_q + (inflight_q ? CW'(2) : CW'(0));
    assign issue       = !reset && !redirect_valid && !halted_q && (committed <= ISSUE_LIMIT);
    assign instr_valid = !reset && !halted_q && (count_q != '0) && (count_q >= CW'(headLen));
    assign pop         = instr_valid && instr_ready && !redirect_valid;
    assign flush       = redirect_valid || hltTake;
    assign push        = inflight_q && !flush && !halted_q;

    assign mem_ren   = issue;
    assign mem_raddr = fetchPc_q;
    assign instr_pc  = instrPc_q;
    assign instr_len = instr_valid ? headLen : 2'd0;
    assign instr     = instr_valid ? {head,
                                      (headLen != 2'd1) ? byte1 : 8'h00,
                                      (headLen == 2'd3) ? byte2 : 8'h00} : 24'h000000;

`ifdef FETCH_HLT_STOP_EN
    assign hltTake = pop && (head == 8'h76);

    always_ff @(posedge clk) begin
        if (reset || redirect_valid) halted_q <= 1'b0;
        else if (hltTake)            halted_q <= 1'b1;
    end
`else
    assign hltTake  = 1'b0;
    assign halted_q = 1'b0;
`endif

    always_comb begin
        rdPtr_d    = rdPtr_q;
        wrPtr_d    = wrPtr_q;
        count_d    = count_q;
        fetchPc_d  = issue ? fetchPc_q + 16'd2 : fetchPc_q;
        instrPc_d  = instrPc_q;
        inflight_d = issue;
        if (redirect_valid) begin
            rdPtr_d   = '0;
            wrPtr_d   = '0;
            count_d   = '0;
            fetchPc_d = redirect_pc;
            instrPc_d = redirect_pc;
        end else begin
            if (pop) begin
                rdPtr_d   = rdPtr_q + PW'(headLen);
                instrPc_d = instrPc_q + 16'(headLen);
            end
            if (push) wrPtr_d = wrPtr_q + PW'(2);
            count_d = count_q + (push ? CW'(2) : CW'(0)) - (pop ? CW'(headLen) : CW'(0));
            if (hltTake) begin
                rdPtr_d = '0;
                wrPtr_d = '0;
                count_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdPtr_q    <= '0;
            wrPtr_q    <= '0;
            count_q    <= '0;
            inflight_q <= 1'b0;
            fetchPc_q  <= RESET_PC;
            instrPc_q  <= RESET_PC;
        end else begin
            rdPtr_q    <= rdPtr_d;
            wrPtr_q    <= wrPtr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            fetchPc_q  <= fetchPc_d;
            instrPc_q  <= instrPc_d;
        end
    end

    // Lower address lands first so the head stays in program order.
    always_ff @(posedge clk) begin
        if (push) begin
            queue_q[wrPtr_q] <= mem_rdata[15:8];
            queue_q[wrPtr1]  <= mem_rdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) assert (count_d <= COUNT_MAX);
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: startup, backpressure, redirect, address wrap, reset mid-flight, HLT.
// Stimulus is one linear sequence; expected values are hand-computed from the program memory image.
module tb_fetch_queue;

    logic        clk;
    logic        reset;
    logic        mem_ren;
    logic [15:0] mem_raddr;
    logic [15:0] mem_rdata;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [23:0] instr;
    logic [15:0] instr_pc;
    logic [1:0]  instr_len;

    logic [7:0] mem [65536];
    int checks   = 0;
    int failures = 0;

    fetch_queue #(.RESET_PC(16'h0000), .QDEPTH(8)) dut (
        .clk(clk), .reset(reset),
        .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc), .instr_len(instr_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program memory answers the cycle after the strobe with {mem[a], mem[a+1]}.
    always @(posedge clk) begin
        if (mem_ren) mem_rdata <= {mem[mem_raddr], mem[16'(mem_raddr + 16'd1)]};
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic r, input logic rv, input logic [15:0] rpc, input logic rdy);
        reset          = r;
        redirect_valid = rv;
        redirect_pc    = rpc;
        instr_ready    = rdy;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        mem[0] = 8'h00; mem[1] = 8'h3E; mem[2] = 8'h42;
        mem[3] = 8'h21; mem[4] = 8'h34; mem[5] = 8'h12;
        mem[6] = 8'hAA; mem[7] = 8'hBB;
        mem[16'h0100] = 8'h06; mem[16'h0101] = 8'h77;
        mem[16'h0102] = 8'hC3; mem[16'h0103] = 8'h00; mem[16'h0104] = 8'h02;
        for (int i = 0; i < 16; i++) mem[16'h0200 + i] = 8'h40 + 8'(i);
        mem[16'h0300] = 8'h76;

        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1);
        cyc();
        cyc();
        checkOutput("rst_valid", 32'(instr_valid), 32'd0);
        checkOutput("rst_instr", 32'(instr), 32'h0);
        checkOutput("rst_len", 32'(instr_len), 32'd0);
        checkOutput("rst_pc", 32'(instr_pc), 32'h0000);
        checkOutput("rst_ren", 32'(mem_ren), 32'd0);

        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
        checkOutput("c0_ren", 32'(mem_ren), 32'd1);
        checkOutput("c0_raddr", 32'(mem_raddr), 32'h0000);
        checkOutput("c0_valid", 32'(instr_valid), 32'd0);
        cyc();
        checkOutput("c1_valid", 32'(instr_valid), 32'd0);
        checkOutput("c1_raddr", 32'(mem_raddr), 32'h0002);
        cyc();
        checkOutput("c2_valid", 32'(instr_valid), 32'd1);
        checkOutput("c2_instr", 32'(instr), 32'h000000);
        checkOutput("c2_len", 32'(instr_len), 32'd1);
        checkOutput("c2_pc", 32'(instr_pc), 32'h0000);
        cyc();
        checkOutput("c3_instr", 32'(instr), 32'h3E4200);
        checkOutput("c3_len", 32'(instr_len), 32'd2);
        checkOutput("c3_pc", 32'(instr_pc), 32'h0001);
        cyc();
        checkOutput("c4_instr", 32'(instr), 32'h213412);
        checkOutput("c4_len", 32'(instr_len), 32'd3);
        checkOutput("c4_pc", 32'(instr_pc), 32'h0003);

        // Redirect while the read of 0x0006 is returning; AA BB must never appear.
        applyStimulus(1'b0, 1'b1, 16'h0100, 1'b1);
        cyc();
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
        checkOutput("j_r1_valid", 32'(instr_valid), 32'd0);
        checkOutput("j_r1_ren", 32'(mem_ren), 32'd1);
        checkOutput("j_r1_raddr", 32'(mem_raddr), 32'h0100);
        checkOutput("j_r1_pc", 32'(instr_pc), 32'h0100);
        cyc();
        checkOutput("j_r2_valid", 32'(instr_valid), 32'd0);
        cyc();
        checkOutput("j_r3_instr", 32'(instr), 32'h067700);
        checkOutput("j_r3_len", 32'(instr_len), 32'd2);
        checkOutput("j_r3_pc", 32'(instr_pc), 32'h0100);
        cyc();
        checkOutput("j_r4_partial", 32'(instr_valid), 32'd0);
        checkOutput("j_r4_pc", 32'(instr_pc), 32'h0102);
        cyc();
        checkOutput("j_r5_instr", 32'(instr), 32'hC30002);
        checkOutput("j_r5_pc", 32'(instr_pc), 32'h0102);

        // Backpressure: redirect to 0x0200 and hold decode off.
        applyStimulus(1'b0, 1'b1, 16'h0200, 1'b0);
        cyc();
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        cyc();
        cyc();
        cyc();
        checkOutput("bp_r4_ren", 32'(mem_ren), 32'd1);
        checkOutput("bp_r4_raddr", 32'(mem_raddr), 32'h0206);
        cyc();
        checkOutput("bp_r5_ren", 32'(mem_ren), 32'd0);
        for (int k = 0; k < 7; k++) cyc();
        checkOutput("bp_hold_ren", 32'(mem_ren), 32'd0);
        checkOutput("bp_hold_valid", 32'(instr_valid), 32'd1);
        checkOutput("bp_hold_instr", 32'(instr), 32'h400000);
        checkOutput("bp_hold_pc", 32'(instr_pc), 32'h0200);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
        for (int i = 0; i < 12; i++) begin
            checkOutput("bp_drain_valid", 32'(instr_valid), 32'd1);
            checkOutput("bp_drain_instr", 32'(instr), {8'h00, 8'h40 + 8'(i), 16'h0000});
            checkOutput("bp_drain_pc", 32'(instr_pc), 32'h0200 + 32'(i));
            cyc();
        end

        // JMP spanning FFFF -> 0000.
        mem[16'hFFFF] = 8'hC3; mem[0] = 8'h10; mem[1] = 8'h20; mem[2] = 8'h00;
        applyStimulus(1'b0, 1'b1, 16'hFFFF, 1'b1);
        cyc();
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
        checkOutput("w_r1_raddr", 32'(mem_raddr), 32'hFFFF);
        cyc();
        cyc();
        checkOutput("w_r3_partial", 32'(instr_valid), 32'd0);
        cyc();
        checkOutput("w_r4_instr", 32'(instr), 32'hC31020);
        checkOutput("w_r4_len", 32'(instr_len), 32'd3);
        checkOutput("w_r4_pc", 32'(instr_pc), 32'hFFFF);
        cyc();
        checkOutput("w_r5_pc", 32'(instr_pc), 32'h0002);
        checkOutput("w_r5_instr", 32'(instr), 32'h000000);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        cyc();
        checkOutput("w_r6_valid", 32'(instr_valid), 32'd1);
        checkOutput("w_r6_pc", 32'(instr_pc), 32'h0002);

        // Reset with five bytes queued and a read in flight.
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        cyc();
        checkOutput("mr_valid", 32'(instr_valid), 32'd0);
        checkOutput("mr_len", 32'(instr_len), 32'd0);
        checkOutput("mr_raddr", 32'(mem_raddr), 32'h0000);
        checkOutput("mr_pc", 32'(instr_pc), 32'h0000);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
        checkOutput("mr_c0_ren", 32'(mem_ren), 32'd1);
        cyc();
        checkOutput("mr_c1_valid", 32'(instr_valid), 32'd0);
        cyc();
        checkOutput("mr_c2_instr", 32'(instr), 32'h100000);
        checkOutput("mr_c2_pc", 32'(instr_pc), 32'h0000);

        // HLT handling.
        applyStimulus(1'b0, 1'b1, 16'h0300, 1'b1);
        cyc();
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
        cyc();
        cyc();
        checkOutput("h_instr", 32'(instr), 32'h760000);
        checkOutput("h_len", 32'(instr_len), 32'd1);
        checkOutput("h_pc", 32'(instr_pc), 32'h0300);
        cyc();
`ifdef FETCH_HLT_STOP_EN
        checkOutput("h_stop_valid", 32'(instr_valid), 32'd0);
        checkOutput("h_stop_ren", 32'(mem_ren), 32'd0);
        cyc();
        cyc();
        checkOutput("h_idle_valid", 32'(instr_valid), 32'd0);
        checkOutput("h_idle_ren", 32'(mem_ren), 32'd0);
        applyStimulus(1'b0, 1'b1, 16'h0010, 1'b1);
        cyc();
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1);
        checkOutput("h_resume_ren", 32'(mem_ren), 32'd1);
        checkOutput("h_resume_raddr", 32'(mem_raddr), 32'h0010);
        cyc();
        cyc();
        checkOutput("h_resume_valid", 32'(instr_valid), 32'd1);
        checkOutput("h_resume_pc", 32'(instr_pc), 32'h0010);
`else
        checkOutput("h_pass_valid", 32'(instr_valid), 32'd1);
        checkOutput("h_pass_instr", 32'(instr), 32'h000000);
        checkOutput("h_pass_pc", 32'(instr_pc), 32'h0301);
        checkOutput("h_pass_ren", 32'(mem_ren), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
